// File: rtl/npc_mem_arbiter.sv
// rtl/npc_mem_arbiter.sv - round-robin IFU/LSU arbiter for the single NPC memory port
// One outstanding transaction; a bounded WAIT timer converts a hung memory into an error response.
module npc_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_rsp_valid,
  output logic [DW-1:0]   ifu_rsp_data,
  output logic            ifu_rsp_err,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_rsp_valid,
  output logic [DW-1:0]   lsu_rsp_data,
  output logic            lsu_rsp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_data
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_next;
  logic              last_lsu;   // 1 when the LSU owned the previous transaction
  logic              owner_lsu;
  logic [TW-1:0]     timer;
  logic [AW-1:0]     addr_q;
  logic              wen_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wmask_q;

  logic grant_ifu, grant_lsu, timeout_hit, done;

  assign grant_ifu   = ifu_req_valid && (!lsu_req_valid || last_lsu);
  assign grant_lsu   = lsu_req_valid && !grant_ifu;
  assign timeout_hit = (timer == TMAX);
  assign done        = (state == WAIT) && (mem_rsp_valid || timeout_hit);

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_ifu || grant_lsu) state_next = REQ;
      REQ:     if (mem_req_ready)          state_next = WAIT;
      WAIT:    if (done)                   state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // Ready is gated by rst so nothing is handshaken while reset is held.
  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = '0;
    ifu_rsp_err   = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_data  = '0;
    lsu_rsp_err   = 1'b0;
    unique case (state)
      IDLE: begin
        ifu_req_ready = grant_ifu && !rst;
        lsu_req_ready = grant_lsu && !rst;
      end
      REQ: mem_req_valid = 1'b1;
      WAIT: begin
        if (done) begin
          if (owner_lsu) begin
            lsu_rsp_valid = 1'b1;
            lsu_rsp_data  = mem_rsp_valid ? mem_rsp_data : '0;
            lsu_rsp_err   = !mem_rsp_valid;
          end else begin
            ifu_rsp_valid = 1'b1;
            ifu_rsp_data  = mem_rsp_valid ? mem_rsp_data : '0;
            ifu_rsp_err   = !mem_rsp_valid;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_lsu  <= 1'b1;
      owner_lsu <= 1'b0;
      timer     <= '0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_ifu || grant_lsu) begin
            owner_lsu <= grant_lsu;
            addr_q    <= grant_lsu ? lsu_addr : ifu_addr;
            wen_q     <= grant_lsu && lsu_wen;
            wdata_q   <= grant_lsu ? lsu_wdata : '0;
            wmask_q   <= grant_lsu ? lsu_wmask : '0;
          end
        end
        REQ: if (mem_req_ready) timer <= '0;
        WAIT: begin
          if (done) last_lsu <= owner_lsu;
          else      timer    <= timer + TW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// tb/tb_npc_mem_arbiter.sv - directed and randomized checks of npc_mem_arbiter against a transaction-level model
module tb_npc_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 0, ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid = 0, lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_rsp_data;
  logic        mem_req_valid, mem_wen;
  logic        mem_req_ready = 0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 0;
  logic [31:0] mem_rsp_data = '0;

  int total = 0;
  int bad   = 0;
  bit model_last_lsu = 1'b1;

  npc_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ifu_ready"}, ifu_req_ready, 0);
    chk({tag, ".lsu_ready"}, lsu_req_ready, 0);
    chk({tag, ".ifu_rsp"},   ifu_rsp_valid, 0);
    chk({tag, ".lsu_rsp"},   lsu_rsp_valid, 0);
    chk({tag, ".mem_req"},   mem_req_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    #1;
    chk_quiet("reset");
    chk("reset.addr",  mem_addr, 0);
    chk("reset.wen",   mem_wen, 0);
    chk("reset.wdata", mem_wdata, 0);
    chk("reset.wmask", mem_wmask, 0);
    step();
    rst = 1'b0;
    model_last_lsu = 1'b1;
  endtask

  // One whole transaction: grant, REQ stall of rdly cycles, response after sdly WAIT cycles.
  task automatic do_txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                        input bit lw, input logic [31:0] lwd, input logic [3:0] lm,
                        input int rdly, input int sdly, input logic [31:0] rd);
    bit g_ifu, to_err;
    int rsp_k;
    logic [31:0] exp_data;
    g_ifu  = iv && (!lv || model_last_lsu);
    to_err = (sdly > TO);
    rsp_k  = to_err ? TO : sdly;
    exp_data = to_err ? 32'h0 : rd;
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lm;
    #1;
    chk("grant.ifu_ready", ifu_req_ready, g_ifu);
    chk("grant.lsu_ready", lsu_req_ready, !g_ifu);
    step();
    if (g_ifu) ifu_req_valid = 0;
    else       lsu_req_valid = 0;
    for (int c = 0; c <= rdly; c++) begin
      mem_req_ready = (c == rdly);
      #1;
      chk("req.valid", mem_req_valid, 1);
      chk("req.addr",  mem_addr, g_ifu ? ia : la);
      chk("req.wen",   mem_wen, g_ifu ? 1'b0 : lw);
      chk("req.wmask", mem_wmask, g_ifu ? 4'h0 : lm);
      if (!g_ifu) chk("req.wdata", mem_wdata, lwd);
      chk("req.ifu_ready", ifu_req_ready, 0);
      chk("req.lsu_ready", lsu_req_ready, 0);
      step();
    end
    mem_req_ready = 0;
    for (int k = 0; k <= rsp_k; k++) begin
      if (k == sdly) begin
        mem_rsp_valid = 1;
        mem_rsp_data  = rd;
      end
      #1;
      if (k < rsp_k) begin
        chk("wait.ifu_rsp", ifu_rsp_valid, 0);
        chk("wait.lsu_rsp", lsu_rsp_valid, 0);
        chk("wait.mem_req", mem_req_valid, 0);
      end else begin
        chk("rsp.ifu_valid", ifu_rsp_valid, g_ifu);
        chk("rsp.lsu_valid", lsu_rsp_valid, !g_ifu);
        chk("rsp.data", g_ifu ? ifu_rsp_data : lsu_rsp_data, exp_data);
        chk("rsp.err",  g_ifu ? ifu_rsp_err  : lsu_rsp_err,  to_err);
      end
      step();
      mem_rsp_valid = 0;
    end
    #1;
    chk("after.ifu_rsp", ifu_rsp_valid, 0);
    chk("after.lsu_rsp", lsu_rsp_valid, 0);
    chk("after.mem_req", mem_req_valid, 0);
    model_last_lsu = !g_ifu;
  endtask

  initial begin
    bit iv, lv;
    step();
    do_reset();

    // tie on every transaction after reset: IFU, LSU, IFU, LSU
    for (int i = 0; i < 4; i++)
      do_txn(1, 1, 32'h8000_0000 + 32'(i * 4), 32'h9000_0000 + 32'(i * 4), 1'b0,
             32'h0, 4'h0, 0, 0, 32'h1000 + 32'(i));

    do_reset();
    do_txn(1, 0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0000_0413);
    do_txn(0, 1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 5, 1, 32'h0);
    do_txn(1, 0, 32'h8000_0010, 32'h0, 1'b0, 32'h0, 4'h0, 0, 50, 32'h1234_5678);
    do_txn(0, 1, 32'h0, 32'h8000_2000, 1'b0, 32'h0, 4'h0, 1, TO, 32'hCAFE_F00D);

    // reset while in WAIT, then a stray response must be ignored
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    step();
    ifu_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    step();
    rst = 1; ifu_req_valid = 1; lsu_req_valid = 1;
    #1;
    chk_quiet("midreset");
    chk("midreset.addr", mem_addr, 0);
    step();
    ifu_req_valid = 0; lsu_req_valid = 0; rst = 0;
    model_last_lsu = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_rsp_valid = 1; mem_rsp_data = 32'h5555_AAAA;
      #1;
      chk_quiet("stray");
      step();
    end
    mem_rsp_valid = 0;
    do_txn(1, 0, 32'h8000_0080, 32'h0, 1'b0, 32'h0, 4'h0, 0, 2, 32'h0BAD_F00D);

    for (int n = 0; n < 40; n++) begin
      iv = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      if (!iv && !lv) iv = 1;
      do_txn(iv, lv, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 6), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
